// File: rtl/command_word_sequencer_pkg.sv
// Shared types and bit positions for the PIC programming front end:
// init-sequence states, ICW/OCW field positions and OCW2 command codes.
package command_word_sequencer_pkg;

   typedef enum logic [2:0] {
      S_UNINIT    = 3'd0,
      S_WAIT_ICW2 = 3'd1,
      S_WAIT_ICW3 = 3'd2,
      S_WAIT_ICW4 = 3'd3,
      S_READY     = 3'd4
   } state_e;

   // ICW1 fields (A0=0, D4=1)
   localparam int ICW1_IC4  = 0;
   localparam int ICW1_SNGL = 1;
   localparam int ICW1_LTIM = 3;
   localparam int CMD_SEL   = 4;

   // ICW4 fields
   localparam int ICW4_AEOI = 1;

   // D3 separates OCW2 (0) from OCW3 (1) once D4=0
   localparam int OCW_SEL   = 3;

   // OCW3 fields
   localparam int OCW3_RIS  = 0;
   localparam int OCW3_RR   = 1;
   localparam int OCW3_P    = 2;
   localparam int OCW3_SMM  = 5;
   localparam int OCW3_ESMM = 6;

   // OCW2 R,SL,EOI command codes
   localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
   localparam logic [2:0] OCW2_EOI          = 3'b001;
   localparam logic [2:0] OCW2_SEOI         = 3'b011;
   localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
   localparam logic [2:0] OCW2_ROT_EOI      = 3'b101;
   localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
   localparam logic [2:0] OCW2_ROT_SEOI     = 3'b111;

   function automatic logic [2:0] ocw2_cmd_of(input logic [7:0] d);
      return d[7:5];
   endfunction

endpackage

// File: rtl/command_word_sequencer_if.sv
// CPU write port of the PIC: qualified active-low strobe, register select and byte.
interface command_word_sequencer_if;
   // Write handshake: a write commits once, in the cycle where the registered
   // strobe is still low and WR_n has returned high; A0 and data_in must be
   // stable in that cycle. There is no back-pressure.
   logic       WR_n;
   logic       A0;
   logic [7:0] data_in;

   modport master (output WR_n, output A0, output data_in);
   modport slave  (input  WR_n, input  A0, input  data_in);
endinterface

// File: rtl/command_word_sequencer_wr_edge_detect.sv
// Registers the write strobe and flags the cycle in which it rises (the commit cycle).
module command_word_sequencer_wr_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic WR_n,
   output logic commit
);

   logic wr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wr_q <= 1'b1;
      else        wr_q <= WR_n;
   end

   assign commit = ~wr_q & WR_n;

endmodule

// File: rtl/command_word_sequencer.sv
// ICW1-ICW4 initialisation sequencer and OCW1-OCW3 command decoder; holds the
// mask, vector base, mode bits and the EOI/rotate/poll/read-select commands.
module command_word_sequencer
   import command_word_sequencer_pkg::*;
#(
   parameter logic [7:0] IMR_RESET      = 8'h00,
   parameter logic [4:0] VEC_BASE_RESET = 5'h00
) (
   input  logic                      clk,
   input  logic                      rst_n,
   command_word_sequencer_if.slave   bus,
   output logic [7:0]                IMR,
   output logic [4:0]                vector_base,
   output logic                      LTIM,
   output logic                      SNGL,
   output logic                      AEOI,
   output logic [7:0]                cascade_cfg,
   output logic                      init_done,
   output logic                      rotate_aeoi,
   output logic                      special_mask,
   output logic                      read_isr,
   output logic                      ocw2_valid,
   output logic [2:0]                ocw2_cmd,
   output logic [2:0]                ocw2_level,
   output logic                      poll_req,
   output state_e                    state_dbg
);

   logic       commit;
   logic       a0;
   logic [7:0] d;

   state_e     state_q, state_d;
   logic       ic4_q, ic4_d;
   logic [7:0] imr_d, cascade_d;
   logic [4:0] vb_d;
   logic       ltim_d, sngl_d, aeoi_d, rot_d, sm_d, ris_d;
   logic       ocw2_valid_d, poll_d;
   logic [2:0] cmd_d, level_d;

   command_word_sequencer_wr_edge_detect u_wr_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .WR_n   (bus.WR_n),
      .commit (commit)
   );

   assign a0 = bus.A0;
   assign d  = bus.data_in;

   always_comb begin
      state_d      = state_q;
      ic4_d        = ic4_q;
      imr_d        = IMR;
      vb_d         = vector_base;
      ltim_d       = LTIM;
      sngl_d       = SNGL;
      aeoi_d       = AEOI;
      cascade_d    = cascade_cfg;
      rot_d        = rotate_aeoi;
      sm_d         = special_mask;
      ris_d        = read_isr;
      cmd_d        = ocw2_cmd;
      level_d      = ocw2_level;
      ocw2_valid_d = 1'b0;
      poll_d       = 1'b0;

      if (commit) begin
         if (!a0 && d[CMD_SEL]) begin
            // ICW1 restarts initialisation from any state
            ic4_d   = d[ICW1_IC4];
            sngl_d  = d[ICW1_SNGL];
            ltim_d  = d[ICW1_LTIM];
            imr_d   = IMR_RESET;
            sm_d    = 1'b0;
            ris_d   = 1'b0;
            rot_d   = 1'b0;
            if (!d[ICW1_IC4]) aeoi_d = 1'b0;
            state_d = S_WAIT_ICW2;
         end else if (a0) begin
            case (state_q)
               S_WAIT_ICW2: begin
                  vb_d = d[7:3];
                  if (!SNGL)      state_d = S_WAIT_ICW3;
                  else if (ic4_q) state_d = S_WAIT_ICW4;
                  else            state_d = S_READY;
               end
               S_WAIT_ICW3: begin
                  cascade_d = d;
                  state_d   = ic4_q ? S_WAIT_ICW4 : S_READY;
               end
               S_WAIT_ICW4: begin
                  aeoi_d  = d[ICW4_AEOI];
                  state_d = S_READY;
               end
               S_READY: imr_d = d;
               default: ;
            endcase
         end else if (state_q == S_READY) begin
            if (!d[OCW_SEL]) begin
               ocw2_valid_d = 1'b1;
               cmd_d        = ocw2_cmd_of(d);
               level_d      = d[2:0];
               if (ocw2_cmd_of(d) == OCW2_ROT_AEOI_SET)      rot_d = 1'b1;
               else if (ocw2_cmd_of(d) == OCW2_ROT_AEOI_CLR) rot_d = 1'b0;
            end else begin
               if (d[OCW3_RR])   ris_d  = d[OCW3_RIS];
               if (d[OCW3_ESMM]) sm_d   = d[OCW3_SMM];
               if (d[OCW3_P])    poll_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_UNINIT;
         ic4_q        <= 1'b0;
         IMR          <= IMR_RESET;
         vector_base  <= VEC_BASE_RESET;
         LTIM         <= 1'b0;
         SNGL         <= 1'b0;
         AEOI         <= 1'b0;
         cascade_cfg  <= 8'h00;
         rotate_aeoi  <= 1'b0;
         special_mask <= 1'b0;
         read_isr     <= 1'b0;
         ocw2_valid   <= 1'b0;
         ocw2_cmd     <= 3'b000;
         ocw2_level   <= 3'b000;
         poll_req     <= 1'b0;
      end else begin
         state_q      <= state_d;
         ic4_q        <= ic4_d;
         IMR          <= imr_d;
         vector_base  <= vb_d;
         LTIM         <= ltim_d;
         SNGL         <= sngl_d;
         AEOI         <= aeoi_d;
         cascade_cfg  <= cascade_d;
         rotate_aeoi  <= rot_d;
         special_mask <= sm_d;
         read_isr     <= ris_d;
         ocw2_valid   <= ocw2_valid_d;
         ocw2_cmd     <= cmd_d;
         ocw2_level   <= level_d;
         poll_req     <= poll_d;
      end
   end

   assign init_done = (state_q == S_READY);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_command_word_sequencer.sv
// Directed bench for command_word_sequencer: a queue-based model of the init
// sequence and command decode is compared against every output each cycle.
module tb_command_word_sequencer;
   import command_word_sequencer_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   command_word_sequencer_if bus();

   logic [7:0] IMR, cascade_cfg;
   logic [4:0] vector_base;
   logic       LTIM, SNGL, AEOI, init_done, rotate_aeoi, special_mask, read_isr;
   logic       ocw2_valid, poll_req;
   logic [2:0] ocw2_cmd, ocw2_level;
   state_e     state_dbg;

   command_word_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .IMR          (IMR),
      .vector_base  (vector_base),
      .LTIM         (LTIM),
      .SNGL         (SNGL),
      .AEOI         (AEOI),
      .cascade_cfg  (cascade_cfg),
      .init_done    (init_done),
      .rotate_aeoi  (rotate_aeoi),
      .special_mask (special_mask),
      .read_isr     (read_isr),
      .ocw2_valid   (ocw2_valid),
      .ocw2_cmd     (ocw2_cmd),
      .ocw2_level   (ocw2_level),
      .poll_req     (poll_req),
      .state_dbg    (state_dbg)
   );

   int checks = 0;
   int errors = 0;
   logic check_en = 1'b0;

   // Model: pending ICWs are kept as a queue of ICW numbers still owed.
   logic [2:0] exp_q[$];
   logic       m_started;
   logic [7:0] m_imr, m_casc;
   logic [4:0] m_vb;
   logic       m_ltim, m_sngl, m_aeoi, m_rot, m_sm, m_ris, m_valid, m_poll;
   logic [2:0] m_cmd, m_level;
   int         edge_cnt = 0;
   int         pulse_edge = -1;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic m_ready();
      return m_started && (exp_q.size() == 0);
   endfunction

   function automatic state_e m_state();
      if (exp_q.size() == 0) return m_started ? S_READY : S_UNINIT;
      case (exp_q[0])
         3'd2:    return S_WAIT_ICW2;
         3'd3:    return S_WAIT_ICW3;
         default: return S_WAIT_ICW4;
      endcase
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_started = 1'b0; m_imr = 8'h00; m_casc = 8'h00; m_vb = 5'h00;
      m_ltim = 1'b0; m_sngl = 1'b0; m_aeoi = 1'b0; m_rot = 1'b0; m_sm = 1'b0;
      m_ris = 1'b0; m_valid = 1'b0; m_poll = 1'b0; m_cmd = 3'b000; m_level = 3'b000;
   endtask

   task automatic model_write(input logic a0, input logic [7:0] d);
      logic [2:0] k;
      if (!a0 && d[4]) begin
         m_sngl = d[1]; m_ltim = d[3];
         m_imr = 8'h00; m_sm = 1'b0; m_ris = 1'b0; m_rot = 1'b0;
         if (!d[0]) m_aeoi = 1'b0;
         exp_q.delete();
         exp_q.push_back(3'd2);
         if (!d[1]) exp_q.push_back(3'd3);
         if (d[0])  exp_q.push_back(3'd4);
         m_started = 1'b1;
      end else if (a0) begin
         if (exp_q.size() != 0) begin
            k = exp_q.pop_front();
            case (k)
               3'd2:    m_vb = d[7:3];
               3'd3:    m_casc = d;
               default: m_aeoi = d[1];
            endcase
         end else if (m_started) begin
            m_imr = d;
         end
      end else if (m_ready()) begin
         if (!d[3]) begin
            m_valid = 1'b1; pulse_edge = edge_cnt;
            m_cmd = d[7:5]; m_level = d[2:0];
            if (d[7:5] == 3'b100)      m_rot = 1'b1;
            else if (d[7:5] == 3'b000) m_rot = 1'b0;
         end else begin
            if (d[1]) m_ris = d[0];
            if (d[6]) m_sm = d[5];
            if (d[2]) begin m_poll = 1'b1; pulse_edge = edge_cnt; end
         end
      end
   endtask

   // Model pulses last one clock: drop them at the edge after they were set.
   always @(posedge clk) begin
      edge_cnt++;
      #2;
      if (edge_cnt != pulse_edge) begin
         m_valid = 1'b0;
         m_poll  = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("imr",          IMR,               m_imr);
         chk("vector_base",  8'(vector_base),   8'(m_vb));
         chk("ltim",         8'(LTIM),          8'(m_ltim));
         chk("sngl",         8'(SNGL),          8'(m_sngl));
         chk("aeoi",         8'(AEOI),          8'(m_aeoi));
         chk("cascade_cfg",  cascade_cfg,       m_casc);
         chk("init_done",    8'(init_done),     8'(m_ready()));
         chk("rotate_aeoi",  8'(rotate_aeoi),   8'(m_rot));
         chk("special_mask", 8'(special_mask),  8'(m_sm));
         chk("read_isr",     8'(read_isr),      8'(m_ris));
         chk("ocw2_valid",   8'(ocw2_valid),    8'(m_valid));
         chk("ocw2_cmd",     8'(ocw2_cmd),      8'(m_cmd));
         chk("ocw2_level",   8'(ocw2_level),    8'(m_level));
         chk("poll_req",     8'(poll_req),      8'(m_poll));
         chk("state",        8'(state_dbg),     8'(m_state()));
      end
   end

   // One WR_n low pulse of one clock; returns just after the first sample of the result.
   task automatic do_write(input logic a0, input logic [7:0] d);
      @(negedge clk);
      bus.WR_n = 1'b0; bus.A0 = a0; bus.data_in = d;
      @(negedge clk);
      bus.WR_n = 1'b1;
      @(posedge clk);
      #1 model_write(a0, d);
      @(negedge clk);
      #1;
   endtask

   initial begin
      bus.WR_n = 1'b1; bus.A0 = 1'b0; bus.data_in = 8'h00;
      rst_n = 1'b0;
      model_reset();
      check_en = 1'b1;
      @(negedge clk); #1;
      chk("rst_imr",   IMR,            8'h00);
      chk("rst_init",  8'(init_done),  8'h00);
      chk("rst_state", 8'(state_dbg),  8'(S_UNINIT));
      @(negedge clk);
      rst_n = 1'b1;

      // 1: single, IC4, AEOI
      do_write(1'b0, 8'h13); do_write(1'b1, 8'h08); do_write(1'b1, 8'h03);
      chk("t1_vb",       8'(vector_base), 8'h01);
      chk("t1_aeoi",     8'(AEOI),        8'h01);
      chk("t1_init",     8'(init_done),   8'h01);
      chk("t1_model_vb", 8'(m_vb),        8'h01);

      // 2: cascade sequence with ICW3
      do_write(1'b0, 8'h11); do_write(1'b1, 8'h20); do_write(1'b1, 8'h04); do_write(1'b1, 8'h01);
      chk("t2_casc",       cascade_cfg,     8'h04);
      chk("t2_vb",         8'(vector_base), 8'h04);
      chk("t2_init",       8'(init_done),   8'h01);
      chk("t2_model_casc", m_casc,          8'h04);

      // 3: OCW1 then ICW1 clears mask
      do_write(1'b1, 8'hA5);
      chk("t3_imr", IMR, 8'hA5);
      do_write(1'b0, 8'h13);
      chk("t3_imr_clr", IMR,             8'h00);
      chk("t3_init",    8'(init_done),   8'h00);
      chk("t3_state",   8'(state_dbg),   8'(S_WAIT_ICW2));
      do_write(1'b1, 8'h08); do_write(1'b1, 8'h00);

      // 4: ICW1 restart from WAIT_ICW3, ignored writes while waiting
      do_write(1'b0, 8'h11); do_write(1'b1, 8'h48);
      chk("t4_state3", 8'(state_dbg), 8'(S_WAIT_ICW3));
      do_write(1'b0, 8'h19);
      chk("t4_state2", 8'(state_dbg), 8'(S_WAIT_ICW2));
      chk("t4_casc",   cascade_cfg,   8'h04);
      chk("t4_ltim",   8'(LTIM),      8'h01);
      do_write(1'b0, 8'h0B);
      chk("t4_ignored", 8'(state_dbg), 8'(S_WAIT_ICW2));
      do_write(1'b1, 8'h08); do_write(1'b1, 8'h02); do_write(1'b1, 8'h02);
      chk("t4_casc2", cascade_cfg, 8'h02);
      chk("t4_aeoi",  8'(AEOI),    8'h01);

      // 5: OCW2 / OCW3
      do_write(1'b0, 8'h63);
      chk("t5_valid", 8'(ocw2_valid), 8'h01);
      chk("t5_cmd",   8'(ocw2_cmd),   8'h03);
      chk("t5_level", 8'(ocw2_level), 8'h03);
      @(negedge clk); #1;
      chk("t5_valid_off", 8'(ocw2_valid), 8'h00);
      chk("t5_cmd_held",  8'(ocw2_cmd),   8'h03);
      do_write(1'b0, 8'h80);
      chk("t5_rot_set", 8'(rotate_aeoi), 8'h01);
      do_write(1'b0, 8'h00);
      chk("t5_rot_clr", 8'(rotate_aeoi), 8'h00);
      do_write(1'b0, 8'h0B);
      chk("t5_ris", 8'(read_isr), 8'h01);
      do_write(1'b0, 8'h0C);
      chk("t5_poll", 8'(poll_req), 8'h01);
      chk("t5_ris_kept", 8'(read_isr), 8'h01);
      @(negedge clk); #1;
      chk("t5_poll_off", 8'(poll_req), 8'h00);
      do_write(1'b0, 8'h68);
      chk("t5_smm", 8'(special_mask), 8'h01);
      do_write(1'b1, 8'h3C);
      chk("t5_imr", IMR, 8'h3C);

      // 6: reset with WR_n low in WAIT_ICW2, then writes in UNINIT ignored
      do_write(1'b0, 8'h13);
      @(negedge clk);
      bus.WR_n = 1'b0; bus.A0 = 1'b1; bus.data_in = 8'h55;
      #2 rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      bus.WR_n = 1'b1;
      @(negedge clk); #1;
      chk("t6_state", 8'(state_dbg),   8'(S_UNINIT));
      chk("t6_vb",    8'(vector_base), 8'h00);
      chk("t6_sngl",  8'(SNGL),        8'h00);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      do_write(1'b1, 8'h77);
      chk("t6_imr_ign",   IMR,           8'h00);
      chk("t6_state_ign", 8'(state_dbg), 8'(S_UNINIT));
      do_write(1'b0, 8'h0B);
      chk("t6_ris_ign", 8'(read_isr), 8'h00);

      // reset while a poll pulse is high
      do_write(1'b0, 8'h12); do_write(1'b1, 8'h10);
      chk("t7_init", 8'(init_done), 8'h01);
      do_write(1'b0, 8'h0C);
      chk("t7_poll", 8'(poll_req), 8'h01);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("t7_poll_rst", 8'(poll_req), 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
